lat_mem_responder: RTL and testbench

- Memory-side responder for the CMU's external memory port (cs/we/addr/data/ack handshake).
- Serves single-word read and write requests from an internal word array after a programmable fixed latency, then acknowledges with a one-cycle ack pulse.
- Drops in as the multi-cycle data memory behind the CMU, so cache-miss and stall paths can be exercised with a controlled latency.
- Exposes its FSM state for the CPUTEST debug view.

---
 rtl/lat_mem_responder.sv | 117 +++++++++++
 tb/tb_lat_mem_responder.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/lat_mem_responder.sv
// Fixed-latency single-word memory responder with a cs/we/addr/data/ack handshake.
// Optional macro LAT_MEM_RANGE_CHECK_EN flags and suppresses out-of-range accesses.
module lat_mem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 4,
  parameter int AW      = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        ack,
  output logic        stall,
  output logic        err,
  output logic [2:0]  ram_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_WAIT = 3'd1,
    WR_WAIT = 3'd2,
    RD_ACK  = 3'd3,
    WR_ACK  = 3'd4
  } state_t;

  state_t        state;
  logic [3:0]    cnt;
  logic [AW-1:0] idx;
  logic [31:0]   wdata;
  logic [31:0]   mem [DEPTH];
  logic          wr_en;
  logic          unused_addr;

  // Byte-offset bits never select anything; upper bits only matter with range checking.
  assign unused_addr = ^{addr[31:AW+2], addr[1:0]};
  assign ram_state   = state;

`ifdef LAT_MEM_RANGE_CHECK_EN
  logic oor;
  logic range_bad;

  assign range_bad = (addr[31:AW+2] != '0);
  assign wr_en     = (state == WR_WAIT) && (cnt == 4'd0) && !rst && !oor;

  always_ff @(posedge clk) begin
    if (rst) begin
      oor <= 1'b0;
      err <= 1'b0;
    end else begin
      if (state == IDLE && cs)
        oor <= range_bad;
      err <= ((state == RD_WAIT || state == WR_WAIT) && cnt == 4'd0) ? oor : 1'b0;
    end
  end
`else
  assign wr_en = (state == WR_WAIT) && (cnt == 4'd0) && !rst;
  assign err   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[idx] <= wdata;
  end

  // Handshake FSM; the request is latched at acceptance so later input changes are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
      idx   <= '0;
      wdata <= 32'd0;
      dout  <= 32'd0;
      ack   <= 1'b0;
      stall <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ack <= 1'b0;
          if (cs) begin
            idx   <= addr[AW+1:2];
            wdata <= din;
            cnt   <= 4'(LATENCY - 1);
            stall <= 1'b1;
            state <= we ? WR_WAIT : RD_WAIT;
          end
        end
        RD_WAIT, WR_WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            stall <= 1'b0;
            ack   <= 1'b1;
            if (state == RD_WAIT) begin
`ifdef LAT_MEM_RANGE_CHECK_EN
              dout <= oor ? 32'hDEADBEEF : mem[idx];
`else
              dout <= mem[idx];
`endif
              state <= RD_ACK;
            end else begin
              state <= WR_ACK;
            end
          end
        end
        default: begin
          ack   <= 1'b0;
          stall <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lat_mem_responder.sv
// Directed bench for lat_mem_responder: one LATENCY=4 instance and one LATENCY=1 instance.
module tb_lat_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs4, we4, cs1, we1;
  logic [31:0] addr4, din4, addr1, din1;
  logic [31:0] dout4, dout1;
  logic        ack4, stall4, err4, ack1, stall1, err1;
  logic [2:0]  state4, state1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lat_mem_responder #(.DEPTH(1024), .LATENCY(4), .AW(10)) u4 (
    .clk(clk), .rst(rst), .cs(cs4), .we(we4), .addr(addr4), .din(din4),
    .dout(dout4), .ack(ack4), .stall(stall4), .err(err4), .ram_state(state4)
  );

  lat_mem_responder #(.DEPTH(1024), .LATENCY(1), .AW(10)) u1 (
    .clk(clk), .rst(rst), .cs(cs1), .we(we1), .addr(addr1), .din(din1),
    .dout(dout1), .ack(ack1), .stall(stall1), .err(err1), .ram_state(state1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One full LATENCY=4 transaction, optionally disturbing addr/din right after acceptance.
  task automatic applyStimulus(input string tag, input logic w, input logic [31:0] a,
                               input logic [31:0] d, input logic chg, input logic [31:0] a_alt,
                               input logic [31:0] d_alt, input logic [31:0] exp_dout,
                               input logic exp_err);
    logic [31:0] wait_code;
    logic [31:0] ack_code;
    wait_code = w ? 32'd2 : 32'd1;
    ack_code  = w ? 32'd4 : 32'd3;
    cs4 = 1'b1; we4 = w; addr4 = a; din4 = d;
    tick();
    checkOutput({tag, "_state_e0"}, 32'(state4), wait_code);
    checkOutput({tag, "_stall_e0"}, 32'(stall4), 32'd1);
    if (chg) begin
      addr4 = a_alt;
      din4  = d_alt;
    end
    for (int k = 1; k <= 3; k++) begin
      tick();
      checkOutput({tag, "_state_wait"}, 32'(state4), wait_code);
      checkOutput({tag, "_stall_wait"}, 32'(stall4), 32'd1);
      checkOutput({tag, "_ack_wait"}, 32'(ack4), 32'd0);
      checkOutput({tag, "_err_wait"}, 32'(err4), 32'd0);
    end
    tick();
    checkOutput({tag, "_ack"}, 32'(ack4), 32'd1);
    checkOutput({tag, "_state_ack"}, 32'(state4), ack_code);
    checkOutput({tag, "_stall_ack"}, 32'(stall4), 32'd0);
    checkOutput({tag, "_err_ack"}, 32'(err4), 32'(exp_err));
    checkOutput({tag, "_dout"}, dout4, exp_dout);
    cs4 = 1'b0;
    tick();
    checkOutput({tag, "_state_idle"}, 32'(state4), 32'd0);
    checkOutput({tag, "_ack_idle"}, 32'(ack4), 32'd0);
    checkOutput({tag, "_err_idle"}, 32'(err4), 32'd0);
  endtask

  logic [31:0] last_rd;

  initial begin
    rst = 1'b1;
    cs4 = 1'b0; we4 = 1'b0; addr4 = 32'd0; din4 = 32'd0;
    cs1 = 1'b0; we1 = 1'b0; addr1 = 32'd0; din1 = 32'd0;
    tick();
    tick();
    checkOutput("rst_state", 32'(state4), 32'd0);
    checkOutput("rst_dout", dout4, 32'd0);
    checkOutput("rst_ack", 32'(ack4), 32'd0);
    checkOutput("rst_stall", 32'(stall4), 32'd0);
    checkOutput("rst_err", 32'(err4), 32'd0);
    rst = 1'b0;
    tick();

    // Write then read back; a write must leave dout at its reset value.
    applyStimulus("wr10", 1'b1, 32'h10, 32'hCAFEBABE, 1'b0, 0, 0, 32'd0, 1'b0);
    applyStimulus("rd10", 1'b0, 32'h10, 32'h0, 1'b0, 0, 0, 32'hCAFEBABE, 1'b0);
    last_rd = 32'hCAFEBABE;

    // Inputs changed after acceptance must not affect the served request.
    applyStimulus("wr20", 1'b1, 32'h20, 32'h20202020, 1'b0, 0, 0, last_rd, 1'b0);
    applyStimulus("wr14", 1'b1, 32'h14, 32'h12345678, 1'b1, 32'h20, 32'h0, last_rd, 1'b0);
    applyStimulus("rd14", 1'b0, 32'h14, 32'h0, 1'b0, 0, 0, 32'h12345678, 1'b0);
    applyStimulus("rd20", 1'b0, 32'h20, 32'h0, 1'b0, 0, 0, 32'h20202020, 1'b0);
    last_rd = 32'h20202020;

    // Reset during WR_WAIT aborts the write and clears dout.
    applyStimulus("wr08", 1'b1, 32'h8, 32'h11111111, 1'b0, 0, 0, last_rd, 1'b0);
    cs4 = 1'b1; we4 = 1'b1; addr4 = 32'h8; din4 = 32'h22222222;
    tick();
    checkOutput("abort_state_wait", 32'(state4), 32'd2);
    tick();
    rst = 1'b1; cs4 = 1'b0;
    tick();
    checkOutput("abort_state", 32'(state4), 32'd0);
    checkOutput("abort_ack", 32'(ack4), 32'd0);
    checkOutput("abort_dout", dout4, 32'd0);
    checkOutput("abort_stall", 32'(stall4), 32'd0);
    rst = 1'b0;
    tick();
    tick();
    tick();
    applyStimulus("rd08", 1'b0, 32'h8, 32'h0, 1'b0, 0, 0, 32'h11111111, 1'b0);

`ifdef LAT_MEM_RANGE_CHECK_EN
    applyStimulus("wr00", 1'b1, 32'h0, 32'h0BADF00D, 1'b0, 0, 0, 32'h11111111, 1'b0);
    applyStimulus("rd_oor", 1'b0, 32'h1000, 32'h0, 1'b0, 0, 0, 32'hDEADBEEF, 1'b1);
    applyStimulus("wr_oor", 1'b1, 32'h1000, 32'hA5A5A5A5, 1'b0, 0, 0, 32'hDEADBEEF, 1'b1);
    applyStimulus("rd00", 1'b0, 32'h0, 32'h0, 1'b0, 0, 0, 32'h0BADF00D, 1'b0);
`else
    applyStimulus("wr_alias", 1'b1, 32'h1000, 32'hA5A5A5A5, 1'b0, 0, 0, 32'h11111111, 1'b0);
    applyStimulus("rd_alias", 1'b0, 32'h0, 32'h0, 1'b0, 0, 0, 32'hA5A5A5A5, 1'b0);
`endif

    // LATENCY=1 instance: fill two words, then back-to-back reads with cs held high.
    cs1 = 1'b1; we1 = 1'b1; addr1 = 32'h0; din1 = 32'h000000AA;
    tick();
    checkOutput("l1_wr0_state", 32'(state1), 32'd2);
    tick();
    checkOutput("l1_wr0_ack", 32'(ack1), 32'd1);
    cs1 = 1'b0;
    tick();
    cs1 = 1'b1; we1 = 1'b1; addr1 = 32'h4; din1 = 32'h000000BB;
    tick();
    tick();
    checkOutput("l1_wr4_ack", 32'(ack1), 32'd1);
    we1 = 1'b0; addr1 = 32'h0;
    tick();
    checkOutput("l1_idle_between", 32'(state1), 32'd0);
    tick();
    checkOutput("l1_rd0_state", 32'(state1), 32'd1);
    checkOutput("l1_rd0_stall", 32'(stall1), 32'd1);
    tick();
    checkOutput("l1_rd0_ack", 32'(ack1), 32'd1);
    checkOutput("l1_rd0_dout", dout1, 32'h000000AA);
    addr1 = 32'h4;
    tick();
    checkOutput("l1_gap_state", 32'(state1), 32'd0);
    checkOutput("l1_gap_ack", 32'(ack1), 32'd0);
    tick();
    checkOutput("l1_rd4_state", 32'(state1), 32'd1);
    tick();
    checkOutput("l1_rd4_ack", 32'(ack1), 32'd1);
    checkOutput("l1_rd4_dout", dout1, 32'h000000BB);
    checkOutput("l1_err", 32'(err1), 32'd0);
    cs1 = 1'b0;
    tick();
    checkOutput("l1_final_state", 32'(state1), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
